score_row_reducer: RTL and testbench
====================================

SCORE_ROW_REDUCER -- requirements
Module: score_row_reducer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning the signed score width.
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the element-count and index width.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock, rising-edge.
REQ-004 The module SHALL have port rst, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The module SHALL have port vld_in, input, 1, meaning the upstream beat is valid.
REQ-006 The module SHALL have port rdy_out, output, 1, meaning the block can accept an upstream beat.
REQ-007 The module SHALL have port score_in, input, DATA_W, meaning a signed two's-complement score.
REQ-008 The module SHALL have port last_in, input, 1, meaning the beat is the final element of a row.
REQ-009 The module SHALL have port vld_out, output, 1, meaning the row result is valid.
REQ-010 The module SHALL have port rdy_in, input, 1, meaning downstream accepts the row result.
REQ-011 The module SHALL have port max_out, output, DATA_W, meaning the signed row maximum.
REQ-012 The module SHALL have port argmax_out, output, CNT_W, meaning the zero-based index of the first maximum.
REQ-013 The module SHALL have port count_out, output, CNT_W, meaning the number of elements in the row, saturating.
REQ-014 The module SHALL have port ovf_out, output, 1, meaning the row exceeded 2^CNT_W-1 elements.

Function
REQ-015 The module SHALL transfer an input beat only on a cycle where vld_in and rdy_out are both 1, and an output result only on a cycle where vld_out and rdy_in are both 1.
REQ-016 The module SHALL implement two states, ACCUM and EMIT: ACCUM drives vld_out=0 and rdy_out=1; EMIT drives vld_out=1 and rdy_out=rdy_in.
REQ-017 In ACCUM, the first beat of a row SHALL load the running max with score_in, argmax with 0, and count with 1; each later beat SHALL increment count.
REQ-018 On a later beat, the module SHALL replace the running max and set argmax to the pre-increment count only if score_in is strictly greater than the running max (signed compare), so ties keep the earliest index.
REQ-019 Count SHALL saturate at 2^CNT_W-1; a beat accepted while count is saturated SHALL set the row's overflow flag and leave argmax unchanged unless the max update rule in REQ-018 applies, in which case argmax SHALL hold 2^CNT_W-1.
REQ-020 A beat accepted with last_in=1 SHALL complete the row: the final max, argmax, count, and overflow values, including that beat, SHALL be registered to the outputs, and the state SHALL become EMIT on the next cycle.
REQ-021 A single-beat row with last_in=1 on the first beat SHALL produce count=1, argmax=0, and max equal to that score.
REQ-022 In EMIT, max_out, argmax_out, count_out, and ovf_out SHALL remain stable while vld_out=1 and rdy_in=0.
REQ-023 In EMIT, when rdy_in=1 and vld_in=0, the module SHALL return to ACCUM on the next cycle with the row accumulator cleared.
REQ-024 In EMIT, when rdy_in=1 and vld_in=1, the result SHALL be consumed and the input beat SHALL be accepted as the first element of the next row in the same cycle, with no bubble; if that beat has last_in=1, the state SHALL remain EMIT with the new result.
REQ-025 Latency SHALL be one cycle from acceptance of the last beat to vld_out=1.
REQ-026 The module SHALL never drop or duplicate a row result, and sustained throughput SHALL be one beat per cycle when rdy_in=1.

Reset
REQ-027 Asserting rst low SHALL asynchronously force state ACCUM, vld_out=0, max_out=0, argmax_out=0, count_out=0, ovf_out=0, and clear the accumulator, and rdy_out SHALL be 1 while in reset.
REQ-028 Reset asserted mid-row or during EMIT SHALL discard the partial or pending row, and the first beat after release SHALL start a new row.

Verification
REQ-029 Scores 3, -5, 7, 7 with last on the fourth beat -> one cycle later vld_out=1, max_out=7, argmax_out=2, count_out=4, ovf_out=0.
REQ-030 Row of all negative scores -2, -9, -1 -> max_out=-1 (16'hFFFF), argmax_out=2, count_out=3.
REQ-031 Row result presented with rdy_in=0 for 5 cycles and vld_in=1 -> outputs are stable, rdy_out=0, and no beat is accepted; when rdy_in rises, the result is consumed and the new beat is counted as index 0.
REQ-032 Back-to-back single-beat rows 10, 20, 30 with rdy_in=1 -> three consecutive vld_out cycles with max_out 10, 20, 30 and count_out=1 each.
REQ-033 Row of 300 beats with CNT_W=8 and the maximum at beat 299 -> count_out=255, ovf_out=1, argmax_out=255.
REQ-034 rst driven low after 2 beats of a row, then the row 4, 1 is sent after release -> max_out=4, argmax_out=0, count_out=2, with no stale data from before reset.

Source files
------------

// File: rtl/score_row_reducer.sv
// Row reducer: signed max, first argmax, saturating count and overflow per row of scores.
// Latency: result valid one cycle after the beat carrying last_in is accepted.
// Backpressure: while a result waits, rdy_out follows rdy_in, so the next row's first beat can be accepted only as the result is consumed.
//
// Ports:
//   clk, rst                 - rising-edge clock, asynchronous active-low reset
//   vld_in/rdy_out           - upstream handshake; score_in (signed), last_in mark the row end
//   vld_out/rdy_in           - downstream handshake for the row result
//   max_out, argmax_out      - signed row maximum and zero-based index of its first occurrence
//   count_out, ovf_out       - saturating element count and "row exceeded 2^CNT_W-1 elements"
module score_row_reducer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  output logic              rdy_out,
  input  logic [DATA_W-1:0] score_in,
  input  logic              last_in,
  output logic              vld_out,
  input  logic              rdy_in,
  output logic [DATA_W-1:0] max_out,
  output logic [CNT_W-1:0]  argmax_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              ovf_out
);

  typedef enum logic {ACCUM, EMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  // Running accumulator for the row in progress; acc_cnt == 0 means no beat yet.
  logic [DATA_W-1:0] acc_max;
  logic [CNT_W-1:0]  acc_arg;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_ovf;

  // Accumulator value after folding in the current beat.
  logic [DATA_W-1:0] nxt_max;
  logic [CNT_W-1:0]  nxt_arg;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              nxt_ovf;

  logic beat;

  // Kept independent of rdy_out to avoid a combinational loop through the FSM block.
  assign beat = vld_in && ((state == ACCUM) || rdy_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vld_out   = 1'b0;
    rdy_out   = 1'b1;
    case (state)
      ACCUM: begin
        if (vld_in && last_in) state_nxt = EMIT;
      end
      EMIT: begin
        vld_out = 1'b1;
        rdy_out = rdy_in;
        // A consumed result either hands over to a fresh row, or, when the
        // accepted beat is itself a one-beat row, stays in EMIT with that result.
        if (rdy_in) begin
          if (vld_in && last_in) state_nxt = EMIT;
          else                   state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    nxt_max = acc_max;
    nxt_arg = acc_arg;
    nxt_cnt = acc_cnt;
    nxt_ovf = acc_ovf;
    if (acc_cnt == '0) begin
      nxt_max = score_in;
      nxt_arg = '0;
      nxt_cnt = CNT_W'(1);
      nxt_ovf = 1'b0;
    end else begin
      if (acc_cnt == CNT_MAX) nxt_ovf = 1'b1;
      else                    nxt_cnt = acc_cnt + CNT_W'(1);
      // Strict compare keeps the earliest index on ties. Once saturated the
      // pre-increment count is pinned at CNT_MAX, which is the index to report.
      if ($signed(score_in) > $signed(acc_max)) begin
        nxt_max = score_in;
        nxt_arg = acc_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_max    <= '0;
      acc_arg    <= '0;
      acc_cnt    <= '0;
      acc_ovf    <= 1'b0;
      max_out    <= '0;
      argmax_out <= '0;
      count_out  <= '0;
      ovf_out    <= 1'b0;
    end else if (beat) begin
      if (last_in) begin
        max_out    <= nxt_max;
        argmax_out <= nxt_arg;
        count_out  <= nxt_cnt;
        ovf_out    <= nxt_ovf;
        acc_max    <= '0;
        acc_arg    <= '0;
        acc_cnt    <= '0;
        acc_ovf    <= 1'b0;
      end else begin
        acc_max <= nxt_max;
        acc_arg <= nxt_arg;
        acc_cnt <= nxt_cnt;
        acc_ovf <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_score_row_reducer.sv
module tb_score_row_reducer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld_in = 1'b0;
  logic        rdy_out;
  logic [15:0] score_in = '0;
  logic        last_in = 1'b0;
  logic        vld_out;
  logic        rdy_in = 1'b0;
  logic [15:0] max_out;
  logic [7:0]  argmax_out;
  logic [7:0]  count_out;
  logic        ovf_out;

  always #5 clk = ~clk;

  score_row_reducer #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .score_in(score_in), .last_in(last_in), .vld_out(vld_out), .rdy_in(rdy_in),
    .max_out(max_out), .argmax_out(argmax_out), .count_out(count_out), .ovf_out(ovf_out)
  );

  typedef struct {
    logic [15:0] mx;
    logic [7:0]  arg;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cur_row[$];   // signed scores of the row being received
  res_t exp_q[$];     // results expected, in order
  bit   pend_last = 0;
  bit   hold_vld  = 0;
  res_t held;
  bit   accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the row result straight from the definition of the reduction.
  function automatic res_t row_result(input int row[$]);
    res_t r;
    int n = row.size();
    int best = row[0];
    int idx = 0;
    foreach (row[i]) if (row[i] > best) begin best = row[i]; idx = i; end
    r.mx  = 16'(best);
    r.arg = (idx > 255) ? 8'd255 : 8'(idx);
    r.cnt = (n > 255) ? 8'd255 : 8'(n);
    r.ovf = (n > 255);
    return r;
  endfunction

  task automatic monitor();
    res_t e;
    if (pend_last) begin chk("latency_vld", 32'(vld_out), 32'd1); pend_last = 0; end
    if (hold_vld) begin
      chk("stable_max", 32'(max_out), 32'(held.mx));
      chk("stable_arg", 32'(argmax_out), 32'(held.arg));
      chk("stable_cnt", 32'(count_out), 32'(held.cnt));
      chk("stable_ovf", 32'(ovf_out), 32'(held.ovf));
      hold_vld = 0;
    end
    if (vld_out && rdy_in) begin
      chk("extra_result", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("max", 32'(max_out), 32'(e.mx));
        chk("argmax", 32'(argmax_out), 32'(e.arg));
        chk("count", 32'(count_out), 32'(e.cnt));
        chk("ovf", 32'(ovf_out), 32'(e.ovf));
      end
    end
    if (vld_out && !rdy_in) begin
      chk("rdy_out_blocked", 32'(rdy_out), 32'd0);
      held.mx = max_out; held.arg = argmax_out; held.cnt = count_out; held.ovf = ovf_out;
      hold_vld = 1;
    end
    accepted = vld_in && rdy_out;
    if (accepted) begin
      cur_row.push_back(int'($signed(score_in)));
      if (last_in) begin
        exp_q.push_back(row_result(cur_row));
        cur_row.delete();
        pend_last = 1;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] s, input logic l, input logic r);
    @(negedge clk);
    vld_in = v; score_in = s; last_in = l; rdy_in = r;
    #1;
    monitor();
    @(posedge clk);
  endtask

  // Offer one beat until it is taken (bounded).
  task automatic send(input logic [15:0] s, input logic l, input logic r);
    int tries = 0;
    do begin
      cycle(1'b1, s, l, r);
      tries++;
    end while (!accepted && tries < 100);
    chk("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld_in = 1'b0; rdy_in = 1'b0; last_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_rdy_out", 32'(rdy_out), 32'd1);
    chk("rst_max", 32'(max_out), 32'd0);
    chk("rst_arg", 32'(argmax_out), 32'd0);
    chk("rst_cnt", 32'(count_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    cur_row.delete(); exp_q.delete(); pend_last = 0; hold_vld = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int tmp;
    logic [15:0] s;
    do_reset();

    // 3, -5, 7, 7 : max 7 at index 2, held 5 cycles with pending input.
    send(16'd3, 0, 0); send(-16'sd5, 0, 0); send(16'd7, 0, 0); send(16'd7, 1, 0);
    cycle(1'b0, '0, 0, 0);
    chk("r1_max", 32'(max_out), 32'd7);
    chk("r1_arg", 32'(argmax_out), 32'd2);
    chk("r1_cnt", 32'(count_out), 32'd4);
    chk("r1_ovf", 32'(ovf_out), 32'd0);
    repeat (5) cycle(1'b1, 16'd99, 1'b0, 1'b0);
    // Result consumed, 99 becomes index 0 of the next row.
    cycle(1'b1, 16'd99, 1'b0, 1'b1);
    chk("r2_first_accept", 32'(accepted), 32'd1);
    send(16'd50, 1, 1);
    cycle(1'b0, '0, 0, 1);

    // All-negative row.
    send(-16'sd2, 0, 0); send(-16'sd9, 0, 0); send(-16'sd1, 1, 0);
    cycle(1'b0, '0, 0, 0);
    chk("neg_max", 32'(max_out), 32'h0000FFFF);
    chk("neg_arg", 32'(argmax_out), 32'd2);
    chk("neg_cnt", 32'(count_out), 32'd3);
    cycle(1'b0, '0, 0, 1);

    // Back-to-back single-beat rows at full rate.
    cycle(1'b1, 16'd10, 1, 1); chk("b2b_10", 32'(accepted), 32'd1);
    cycle(1'b1, 16'd20, 1, 1); chk("b2b_20", 32'(accepted), 32'd1);
    cycle(1'b1, 16'd30, 1, 1); chk("b2b_30", 32'(accepted), 32'd1);
    cycle(1'b0, '0, 0, 1);
    cycle(1'b0, '0, 0, 1);

    // 300-beat row, max at beat 299.
    for (int i = 0; i < 300; i++) begin
      s = (i == 299) ? 16'd2000 : 16'($urandom_range(0, 999));
      send(s, (i == 299), 1);
    end
    cycle(1'b0, '0, 0, 0);
    chk("long_cnt", 32'(count_out), 32'd255);
    chk("long_ovf", 32'(ovf_out), 32'd1);
    chk("long_arg", 32'(argmax_out), 32'd255);
    chk("long_max", 32'(max_out), 32'd2000);
    cycle(1'b0, '0, 0, 1);

    // Reset mid-row, then row 4, 1.
    send(16'd500, 0, 1); send(16'd600, 0, 1);
    do_reset();
    send(16'd4, 0, 1); send(16'd1, 1, 1);
    cycle(1'b0, '0, 0, 0);
    chk("post_rst_max", 32'(max_out), 32'd4);
    chk("post_rst_arg", 32'(argmax_out), 32'd0);
    chk("post_rst_cnt", 32'(count_out), 32'd2);
    cycle(1'b0, '0, 0, 1);

    // Reset while a result is pending.
    send(16'd8, 1, 0);
    cycle(1'b0, '0, 0, 0);
    do_reset();
    cycle(1'b0, '0, 0, 1);
    chk("rst_emit_drop", 32'(vld_out), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      tmp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7)) - 4;
      cycle(($urandom_range(0, 3) != 0), 16'(tmp), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end
    // Close any open row and drain.
    send(16'd0, 1, 1);
    repeat (4) cycle(1'b0, '0, 0, 1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_vld", 32'(vld_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
